// File: rtl/trig_record_fifo.sv
// Timestamps newly rising trigger patterns and queues {pattern, ts} records,
// drained as two 32-bit words per record through a read-enable/valid port.
module trig_record_fifo #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 56
) (
    input  logic                     clk_adc,
    input  logic                     reset,
    input  logic                     ts_clear,
    input  logic                     arm,
    input  logic [7:0]               trig_active,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   rec_count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    input  logic                     clear_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 8 + TS_WIDTH;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [TS_WIDTH-1:0] ts_q;
    logic [7:0]          prev_q;
    logic                evt_vld_q;
    logic [7:0]          evt_pat_q;
    logic [TS_WIDTH-1:0] evt_ts_q;
    logic [RW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_idx_q;
    logic [AW-1:0]       rd_idx_q;
    logic                word_ptr_q;
    logic [AW:0]         count_q;
    logic [31:0]         rd_data_q;
    logic                rd_valid_q;
    logic                ovf_q;
    logic [15:0]         drop_q;

    logic [7:0]          rise;
    logic                evt_d;
    logic [RW-1:0]       head;
    logic                rd_ok;
    logic                pop;
    logic                wr;
    logic                drop;
    logic [AW:0]         count_d;
    logic                ovf_d;
    logic [15:0]         drop_d;

    function automatic logic [31:0] first_word(input logic [RW-1:0] rec);
        logic [23:0] hi;
        hi = '0;
        hi[TS_WIDTH-33:0] = rec[TS_WIDTH-1:32];
        return {rec[RW-1:TS_WIDTH], hi};
    endfunction

    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign rec_count  = count_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

    always_comb begin
        rise    = trig_active & ~prev_q;
        evt_d   = arm && (rise != 8'd0);
        head    = mem_q[rd_idx_q];
        rd_ok   = rd_en && !empty;
        pop     = rd_ok && word_ptr_q;
        // A pop in the same cycle frees the slot, so full-plus-pop never drops.
        wr      = evt_vld_q && (!full || pop);
        drop    = evt_vld_q && !wr;
        count_d = count_q;
        if (wr && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !wr) begin
            count_d = count_q - (AW+1)'(1);
        end
        // A clear coinciding with a drop still accounts for that drop.
        if (clear_overflow) begin
            ovf_d  = drop;
            drop_d = {15'd0, drop};
        end else begin
            ovf_d  = ovf_q | drop;
            drop_d = drop_q;
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            ts_q       <= '0;
            prev_q     <= '0;
            evt_vld_q  <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            word_ptr_q <= 1'b0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_clear ? '0 : ts_q + TS_WIDTH'(1);
            prev_q     <= trig_active;
            evt_vld_q  <= evt_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_ok;
            if (wr) begin
                wr_idx_q <= wr_idx_q + AW'(1);
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + AW'(1);
            end
            if (rd_ok) begin
                word_ptr_q <= ~word_ptr_q;
                rd_data_q  <= word_ptr_q ? head[31:0] : first_word(head);
            end
        end
    end

    // Event capture stage, then record storage one edge later.
    always_ff @(posedge clk_adc) begin
        evt_pat_q <= rise;
        evt_ts_q  <= ts_q;
        if (wr) begin
            mem_q[wr_idx_q] <= {evt_pat_q, evt_ts_q};
        end
    end
endmodule

// File: tb/tb_trig_record_fifo.sv
// Scoreboard bench for trig_record_fifo: a cycle model queues expected records
// and words, every DUT read word is popped and compared in order.
module tb_trig_record_fifo;
    localparam int DEPTH    = 16;
    localparam int TS_WIDTH = 56;

    logic        clk_adc = 1'b0;
    logic        reset = 1'b1;
    logic        ts_clear = 1'b0;
    logic        arm = 1'b0;
    logic [7:0]  trig_active = 8'd0;
    logic        rd_en = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [$clog2(DEPTH):0] rec_count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic [15:0] drop_count;

    trig_record_fifo #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
        .clk_adc(clk_adc), .reset(reset), .ts_clear(ts_clear), .arm(arm),
        .trig_active(trig_active), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .rec_count(rec_count), .empty(empty), .full(full),
        .overflow(overflow), .drop_count(drop_count), .clear_overflow(clear_overflow)
    );

    always #5 clk_adc = ~clk_adc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [55:0] ts_m = '0;
    logic [7:0]  prev_m = '0;
    bit          pend_v = 1'b0;
    logic [63:0] pend_rec = '0;
    logic [63:0] recq[$];
    logic [31:0] expw[$];
    bit          wptr_m = 1'b0;
    bit          ovf_m = 1'b0;
    int          drop_m = 0;
    bit          exp_vld = 1'b0;
    bit          got_vld;
    logic [31:0] got_word;
    logic [31:0] rw[$];

    task automatic tick();
        bit rd_ok, pop, wr, drp;
        logic [7:0]  rise;
        logic [63:0] h;
        @(posedge clk_adc);
        if (reset) begin
            ts_m = '0; prev_m = '0; pend_v = 1'b0; recq.delete(); expw.delete();
            wptr_m = 1'b0; ovf_m = 1'b0; drop_m = 0; exp_vld = 1'b0;
        end else begin
            rd_ok   = rd_en && (recq.size() > 0);
            pop     = rd_ok && wptr_m;
            exp_vld = rd_ok;
            if (rd_ok) begin
                h = recq[0];
                expw.push_back(wptr_m ? h[31:0] : {h[63:56], h[55:32]});
            end
            wr  = pend_v && ((recq.size() < DEPTH) || pop);
            drp = pend_v && !wr;
            if (pop) void'(recq.pop_front());
            if (wr) recq.push_back(pend_rec);
            if (clear_overflow) begin
                ovf_m  = drp;
                drop_m = drp ? 1 : 0;
            end else if (drp) begin
                ovf_m = 1'b1;
                if (drop_m < 65535) drop_m++;
            end
            if (rd_ok) wptr_m = !wptr_m;
            rise     = trig_active & ~prev_m;
            pend_v   = arm && (rise != 8'd0);
            pend_rec = {rise, ts_m};
            prev_m   = trig_active;
            ts_m     = ts_clear ? 56'd0 : ts_m + 56'd1;
        end
        #1;
        got_vld  = rd_valid;
        got_word = rd_data;
        check("rd_valid", 64'(rd_valid), 64'(exp_vld));
        if (exp_vld) check("rd_data", 64'(rd_data), 64'(expw.pop_front()));
        check("rec_count", 64'(rec_count), 64'(recq.size()));
        check("empty", 64'(empty), 64'(recq.size() == 0));
        check("full", 64'(full), 64'(recq.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(ovf_m));
        check("drop_count", 64'(drop_count), 64'(drop_m));
    endtask

    task automatic pulse_evt(input logic [7:0] p);
        trig_active = p;
        tick();
        trig_active = 8'd0;
        tick();
    endtask

    task automatic read_n(input int n);
        rw.delete();
        rd_en = 1'b1;
        repeat (n) begin
            tick();
            if (got_vld) rw.push_back(got_word);
        end
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_rec_count"}, 64'(rec_count), 64'd0);
        check({tag, "_empty"}, 64'(empty), 64'd1);
        check({tag, "_full"}, 64'(full), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("rst");

        // single event at ts=10
        arm = 1'b1;
        ts_clear = 1'b1;
        tick();
        ts_clear = 1'b0;
        for (int i = 0; i < 20 && ts_m != 56'd10; i++) tick();
        trig_active = 8'h05;
        tick();
        tick();
        check("t1_count", 64'(rec_count), 64'd1);
        rd_en = 1'b1;
        tick();
        check("t1_vld0", 64'(rd_valid), 64'd1);
        check("t1_w0", 64'(rd_data), 64'h0500_0000);
        check("t1_not_empty", 64'(empty), 64'd0);
        tick();
        check("t1_vld1", 64'(rd_valid), 64'd1);
        check("t1_w1", 64'(rd_data), 64'h0000_000A);
        check("t1_empty", 64'(empty), 64'd1);
        rd_en = 1'b0;
        tick();
        check("t1_vld_low", 64'(rd_valid), 64'd0);
        trig_active = 8'h00;
        tick();

        // level hold produces one record per newly rising bit set
        trig_active = 8'h01;
        repeat (20) tick();
        trig_active = 8'h03;
        repeat (3) tick();
        check("t2_count", 64'(rec_count), 64'd2);
        read_n(4);
        check("t2_words", 64'(rw.size()), 64'd4);
        w = rw[0];
        check("t2_pat0", 64'(w[31:24]), 64'h01);
        w = rw[2];
        check("t2_pat1", 64'(w[31:24]), 64'h02);
        trig_active = 8'h00;
        arm = 1'b0;
        tick();
        trig_active = 8'h01;
        repeat (20) tick();
        trig_active = 8'h03;
        repeat (3) tick();
        check("t2_disarm_count", 64'(rec_count), 64'd0);
        check("t2_disarm_drop", 64'(drop_count), 64'd0);
        trig_active = 8'h00;
        arm = 1'b1;
        repeat (2) tick();

        // overflow: 18 events into 16 slots
        for (int i = 0; i < 18; i++) pulse_evt(8'h80 >> (i % 8));
        tick();
        check("t3_full", 64'(full), 64'd1);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_drop", 64'(drop_count), 64'd2);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("t3_clr_ovf", 64'(overflow), 64'd0);
        check("t3_clr_drop", 64'(drop_count), 64'd0);

        // full FIFO, event lands on the word-1 pop
        rd_en = 1'b1;
        trig_active = 8'h40;
        tick();
        tick();
        rd_en = 1'b0;
        trig_active = 8'h00;
        check("t4_count", 64'(rec_count), 64'd16);
        check("t4_drop", 64'(drop_count), 64'd0);
        check("t4_overflow", 64'(overflow), 64'd0);
        read_n(2 * DEPTH);
        check("t4_words", 64'(rw.size()), 64'd32);
        w = rw[30];
        check("t4_last_pat", 64'(w[31:24]), 64'h40);
        tick();

        // high timestamp bits, then 40 records across index wrap
        force dut.ts_q = 56'h1_0000_0003;
        ts_m = 56'h1_0000_0003;
        trig_active = 8'h21;
        tick();
        release dut.ts_q;
        ts_clear = 1'b1;
        tick();
        ts_clear = 1'b0;
        trig_active = 8'h00;
        read_n(2);
        check("t5_words", 64'(rw.size()), 64'd2);
        w = rw[0];
        check("t5_w0", 64'(w), 64'h2100_0001);
        w = rw[1];
        check("t5_w1", 64'(w), 64'h0000_0003);
        for (int i = 0; i < 120; i++) begin
            trig_active = (i % 3 == 0) ? 8'(i / 3 + 1) : 8'h00;
            rd_en = (i % 4 != 0);
            tick();
        end
        trig_active = 8'h00;
        rd_en = 1'b0;
        read_n(2 * DEPTH + 4);
        check("t5_drop", 64'(drop_count), 64'd0);
        check("t5_empty", 64'(empty), 64'd1);

        // reset between word 0 and word 1
        pulse_evt(8'h77);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t6_w0_vld", 64'(rd_valid), 64'd1);
        w = rd_data;
        check("t6_w0_pat", 64'(w[31:24]), 64'h77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("t6");
        rd_en = 1'b1;
        tick();
        check("t6_rd_empty", 64'(rd_valid), 64'd0);
        rd_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/trig_record_fifo.md
# trig_record_fifo

Downstream of the trigger-decision logic. It timestamps each newly fired trigger pattern on `clk_adc` and stores pattern plus timestamp in a DEPTH-deep record FIFO. It drains the FIFO as 32-bit words through a read-enable/valid handshake to the board readout path. It replaces the fixed 8-slot `triggerFired`/`clockCounter` arrays with a proper queue, adds overflow accounting, and gives the host a gap-free stream of trigger records.

## Interface
- `DEPTH`, default 16: number of records held; power of 2, ≥2.
- `TS_WIDTH`, default 56: timestamp width; 33..56.
- `clk_adc` in 1: the only clock.
- `reset` in 1: synchronous, active-high reset.
- `ts_clear` in 1: zeroes the timestamp counter on the next edge; the FIFO is unaffected.
- `arm` in 1: when 0, new rising edges are ignored (not stored, not counted as overflow).
- `trig_active` in 8: per-trigger "firing/deadtime" level from trigger logic, bit i = trigger i.
- `rd_en` in 1: host read request, one word per asserted cycle.
- `rd_data` out 32: read word.
- `rd_valid` out 1: `rd_data` valid this cycle.
- `rec_count` out clog2(DEPTH)+1: records stored.
- `empty`, `full` out 1: FIFO status.
- `overflow` out 1: sticky; set when a record is dropped.
- `drop_count` out 16: saturating count of dropped records.
- `clear_overflow` in 1: clears `overflow` and `drop_count`.

## Operation
- Timestamp `ts` (TS_WIDTH bits) increments every cycle and wraps to 0 after all-ones. On `ts_clear` it becomes 0; increment resumes the following cycle.
- Edge detect: `prev` ← `trig_active` every cycle. `rise = trig_active & ~prev`. An event exists when `rise != 0` and `arm == 1`.
- Record contents: `pattern = rise` (all simultaneously rising bits in one record), plus `ts` as sampled in the same cycle the rise is seen.
- Write rules:
  - The record is written if `rec_count < DEPTH`, or if a pop happens in the same cycle.
  - Otherwise it is dropped: `overflow` ← 1 and `drop_count` +1, saturating at 0xFFFF.
  - If `clear_overflow` and a drop coincide, the clear wins and the drop is counted afterward, so `drop_count` = 1 and `overflow` = 1.
- Read words, with the record split into two words:
  - Word 0 = {pattern[7:0], ts[TS_WIDTH-1:32] zero-extended to 24 bits}.
  - Word 1 = ts[31:0].
  - A 1-bit word pointer starts at 0. `rd_en` with `empty == 0` returns the current word and toggles the pointer. The record is popped when word 1 is returned.
  - `rd_en` while `empty == 1` is ignored: pointer unchanged, `rd_valid` stays 0.
  - `empty` does not assert until word 1 of the last record is read.
- `rec_count` covers:
  - +1 on write only.
  - −1 on pop only.
  - Unchanged on simultaneous write and pop.
- `full` = (`rec_count` == DEPTH). `empty` = (`rec_count` == 0).
- Storage: circular buffer with wrapping write and read indices, clog2(DEPTH) bits each.
- `reset` clears all state in the same cycle:
  - `ts`, `prev`, indices, word pointer, `rec_count` = 0.
  - `rd_valid` = 0, `rd_data` = 0, `overflow` = 0, `drop_count` = 0.
  - Storage contents need not be cleared.
- A reset asserted between word 0 and word 1 discards the partial record. The next read after reset returns word 0 of a new record.

## Timing
- Rise seen on `trig_active` at edge n → record written at edge n+1. `rec_count`/`empty` reflect it after edge n+1.
- `rd_en` sampled at edge n → `rd_data`/`rd_valid` registered at edge n+1, held for one cycle. `rd_valid` returns to 0 unless `rd_en` stays high.
- Back-to-back `rd_en` gives one word per cycle with no bubbles.
- A record written at edge n is readable by `rd_en` sampled at edge n+1.
- The pop and the write decision use `rec_count` before the edge plus the same-cycle pop term, so full-plus-pop never drops.
- Reset values of outputs: `rd_data` = 0, `rd_valid` = 0, `rec_count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `drop_count` = 0.

## Test plan
- Single event:
  - Stimulus: reset, `arm`=1, `ts_clear` pulse, then `trig_active` 0x00→0x05 at ts=10.
  - Required response: `rec_count`=1. Two reads return 0x05000000 then 0x0000000A, with `rd_valid` one cycle after each `rd_en`. `empty`=1 after the second word.
- Level hold and arm:
  - Stimulus: `trig_active`=0x01 held for 20 cycles, then 0x03.
  - Required response: exactly 2 records, patterns 0x01 and 0x02.
  - Stimulus: repeat the sequence with `arm`=0.
  - Required response: 0 records and `drop_count`=0.
- Overflow:
  - Stimulus: DEPTH=16, 18 events, no reads.
  - Required response: `full`=1, `overflow`=1, `drop_count`=2. The 16 stored timestamps are those of the first 16 events.
  - Stimulus: `clear_overflow`.
  - Required response: `overflow`=0 and `drop_count`=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full; an event occurs in the cycle `rd_en` reads word 1.
  - Required response: no drop, `rec_count` stays 16, and the new record appears last in order.
- Wrap and high timestamp bits:
  - Stimulus: preload `ts` near 2^32 via a long run (or a force), then an event at ts=0x1_0000_0003; also push 40 records through with interleaved reads.
  - Required response: word 0 = {pattern, 0x000001}, word 1 = 0x00000003. Records come out in FIFO order across index wrap.
- Reset mid-record:
  - Stimulus: read word 0 of a record, then assert `reset` for one cycle.
  - Required response: all outputs at reset values, `empty`=1, and a subsequent `rd_en` yields no `rd_valid`.
